padder_param: RTL and testbench
===============================

PADDER_PARAM -- requirements
Module: padder_param

Interface
REQ-001 SHALL provide parameter RATE_WORDS, default 9, meaning sponge rate in 64-bit words; legal range 1..21 (9 = 576-bit rate).
REQ-002 SHALL provide parameter OUT_W, default RATE_WORDS*64, meaning width of the block output; derived, not overridden.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in  input  64  message word; first message byte in in[63:56], byte k in in[63-8k:56-8k].
REQ-006 SHALL have port in_ready  input  1  user word valid.
REQ-007 SHALL have port is_last  input  1  marks the final message word; qualified by in_ready.
REQ-008 SHALL have port byte_num  input  3  count of valid bytes (0..7) in the is_last word; ignored otherwise.
REQ-009 SHALL have port mode  input  2  padding domain: 0 = Keccak (0x01), 1 = SHA-3 (0x06), 2 = SHAKE (0x1F), 3 = treated as 0.
REQ-010 SHALL have port buffer_full  output  1  to user; a word presented while high is not accepted.
REQ-011 SHALL have port out  output  OUT_W  padded block to the permutation; first word in out[OUT_W-1:OUT_W-64].
REQ-012 SHALL have port out_ready  output  1  block valid to the permutation.
REQ-013 SHALL have port out_last  output  1  valid with out_ready; high when the block is the final block of a message.
REQ-014 SHALL have port f_ack  input  1  from the permutation; block consumed.

Function
REQ-015 SHALL implement states ABSORB, PAD, HOLD; reset state ABSORB.
REQ-016 SHALL accept a word when state = ABSORB, in_ready = 1, and buffer_full = 0; accepted word shifts into out: out <= {out[OUT_W-65:0], w}.
REQ-017 SHALL keep word counter cnt (0..RATE_WORDS); each shifted word increments cnt; buffer_full = out_ready = (cnt == RATE_WORDS).
REQ-018 SHALL latch mode on the first accepted word of each message; later mode changes within the message are ignored.
REQ-019 SHALL, for an accepted non-last word, shift in unchanged.
REQ-020 SHALL, for an accepted is_last word, shift bytes 0..byte_num-1 from in, byte byte_num = domain byte (per latched mode), remaining bytes 0, then enter PAD.
REQ-021 SHALL, in PAD with buffer_full = 0, shift one all-zero word per cycle without user input.
REQ-022 SHALL OR 0x80 into bits [7:0] of whichever word fills position cnt = RATE_WORDS-1 of the final block, including an is_last word landing there (e.g. SHA-3, byte_num = 7 -> final byte 0x86).
REQ-023 SHALL enter HOLD when cnt reaches RATE_WORDS; out_last = 1 in HOLD if the block came from PAD or contained the is_last word, else 0.
REQ-024 SHALL, in HOLD, keep out, out_ready and out_last stable until f_ack.
REQ-025 SHALL, on f_ack in HOLD, clear out to 0 and cnt to 0 next cycle and go to ABSORB; if out_last was 1, the next accepted word starts a new message (mode relatched).
REQ-026 SHALL ignore f_ack when out_ready = 0.
REQ-027 SHALL NOT accept a word in the f_ack cycle; earliest acceptance is the following cycle.
REQ-028 SHALL ignore is_last and byte_num unless the word is accepted (no state change on an unaccepted is_last).
REQ-029 SHALL produce exactly one final block per message; the pad always fits the current block since byte_num <= 7.

Reset
REQ-030 SHALL on reset set out = 0, cnt = 0, out_ready = 0, buffer_full = 0, out_last = 0, state ABSORB, latched mode 0.
REQ-031 SHALL let reset override f_ack and in_ready in the same cycle and abandon any partial message.

Verification
REQ-032 SHALL verify: RATE_WORDS=9, mode=1, one is_last word byte_num=0 -> after 9 cycles out = {64'h0600..00, 7x 64'h0, 64'h0000..0080}, out_last=1.
REQ-033 SHALL verify: 9 full words then is_last byte_num=3 -> block 1 out_last=0 equals words unchanged; after f_ack block 2 word 0 = {3 bytes, 0x01 or mode byte, 0...}, last byte 0x80, out_last=1.
REQ-034 SHALL verify: mode=1, 8 words then is_last byte_num=7 as 9th word -> final byte of out = 0x86, out_last=1, no extra block.
REQ-035 SHALL verify: in_ready held high during HOLD with f_ack delayed 5 cycles -> out stable, no words accepted, first word accepted cycle after f_ack.
REQ-036 SHALL verify: f_ack pulsed while out_ready=0, and mode changed mid-message -> no effect on cnt/out; domain byte uses mode sampled on first word.
REQ-037 SHALL verify: reset asserted mid-PAD at cnt=4 -> next cycle all outputs 0, state ABSORB, new message pads correctly.

Source files
------------

// File: rtl/padder_param_if.sv
// Bundle of the user-side and permutation-side signals of the sponge padder.
// The master side drives the message words and f_ack. The slave side is the
// padder, which returns the padded block and the flow-control flags.
interface padder_param_if #(
    parameter int RATE_WORDS = 9
);
    localparam int OUT_W = RATE_WORDS * 64;

    logic [63:0]      in;
    logic             in_ready;
    logic             is_last;
    logic [2:0]       byte_num;
    logic [1:0]       mode;
    logic             buffer_full;
    logic [OUT_W-1:0] out;
    logic             out_ready;
    logic             out_last;
    logic             f_ack;

    modport master (
        output in, in_ready, is_last, byte_num, mode, f_ack,
        input  buffer_full, out, out_ready, out_last
    );

    modport slave (
        input  in, in_ready, is_last, byte_num, mode, f_ack,
        output buffer_full, out, out_ready, out_last
    );
endinterface

// File: rtl/padder_param.sv
// Sponge input padder. It packs 64-bit message words into RATE_WORDS-word
// blocks and adds the domain byte and the closing 0x80 pad bit. It hands each
// full block to the permutation and waits for f_ack before it starts the next.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// ABSORB | accepting user words into the block buffer
// PAD    | message ended; filling the rest of the final block with zeros
// HOLD   | block full and presented; waiting for f_ack from the permutation
module padder_param #(
    parameter int RATE_WORDS = 9,
    parameter int OUT_W      = RATE_WORDS * 64
) (
    input  logic          clk,
    input  logic          reset,
    padder_param_if.slave bus
);
    localparam int CW = $clog2(RATE_WORDS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RATE_WORDS);
    localparam logic [CW-1:0] CNT_TAIL = CW'(RATE_WORDS - 1);

    typedef enum logic [1:0] {ABSORB, PAD, HOLD} state_t;

    state_t           state;
    logic [OUT_W-1:0] out_q;
    logic [CW-1:0]    cnt;
    logic             out_last_q;
    logic [1:0]       mode_q;
    logic             msg_start;

    logic             full;
    logic             accept;
    logic             at_tail;
    logic [1:0]       mode_sel;
    logic [7:0]       dom;
    logic [63:0]      keep_mask;
    logic [5:0]       dom_shift;
    logic [63:0]      base_word;
    logic [63:0]      word;
    logic             final_word;
    logic [OUT_W-1:0] shifted;

    assign full            = (cnt == CNT_FULL);
    assign bus.buffer_full = full;
    assign bus.out_ready   = full;
    assign bus.out         = out_q;
    assign bus.out_last    = out_last_q;

    // The word to shift in: raw, truncated and padded with the domain byte, or zero fill.
    always_comb begin
        accept     = (state == ABSORB) && bus.in_ready && !full;
        at_tail    = (cnt == CNT_TAIL);
        // The first word of a message uses the live mode because the latch updates on that same edge.
        mode_sel   = msg_start ? bus.mode : mode_q;
        case (mode_sel)
            2'd1:    dom = 8'h06;
            2'd2:    dom = 8'h1F;
            default: dom = 8'h01;
        endcase
        keep_mask  = ~(64'hFFFF_FFFF_FFFF_FFFF >> {bus.byte_num, 3'b000});
        dom_shift  = {3'd7 - bus.byte_num, 3'b000};
        base_word  = bus.in;
        final_word = 1'b0;
        if (state == PAD) begin
            base_word  = 64'h0;
            final_word = 1'b1;
        end else if (bus.is_last) begin
            base_word  = (bus.in & keep_mask) | ({56'h0, dom} << dom_shift);
            final_word = 1'b1;
        end
        word    = base_word | ((final_word && at_tail) ? 64'h80 : 64'h0);
        shifted = (out_q << 64) | OUT_W'(word);
    end

    // Block FSM: absorb, pad, then hold the block until the permutation acknowledges it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ABSORB;
            out_q      <= '0;
            cnt        <= '0;
            out_last_q <= 1'b0;
            mode_q     <= 2'd0;
            msg_start  <= 1'b1;
        end else begin
            case (state)
                ABSORB: begin
                    if (accept) begin
                        out_q <= shifted;
                        cnt   <= cnt + CW'(1);
                        if (msg_start) begin
                            mode_q    <= bus.mode;
                            msg_start <= 1'b0;
                        end
                        if (at_tail) begin
                            state      <= HOLD;
                            out_last_q <= bus.is_last;
                        end else if (bus.is_last) begin
                            state <= PAD;
                        end
                    end
                end
                PAD: begin
                    out_q <= shifted;
                    cnt   <= cnt + CW'(1);
                    if (at_tail) begin
                        state      <= HOLD;
                        out_last_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.f_ack) begin
                        out_q      <= '0;
                        cnt        <= '0;
                        state      <= ABSORB;
                        out_last_q <= 1'b0;
                        // A final block closes the message, so the next accepted word relatches mode.
                        msg_start  <= out_last_q;
                    end
                end
                default: state <= ABSORB;
            endcase
        end
    end
endmodule

// File: tb/tb_padder_param.sv
// Bench for padder_param. A byte-level model pads each message: it appends the
// domain byte, zero-fills to a whole number of blocks and sets 0x80 in the last
// byte. The bench checks each presented block against that model.
module tb_padder_param;
    localparam int RW    = 9;
    localparam int OUT_W = RW * 64;
    localparam int RB    = RW * 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   hold_delay = -1;

    logic [OUT_W-1:0] exp_q[$];
    bit               exp_last_q[$];
    logic [OUT_W-1:0] last_block;

    padder_param_if #(.RATE_WORDS(RW)) bus ();

    padder_param #(.RATE_WORDS(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dom_byte(input int md);
        if (md == 1) return 8'h06;
        if (md == 2) return 8'h1F;
        return 8'h01;
    endfunction

    // Called at a negedge with out_ready high: compare, optionally wait, then acknowledge.
    task automatic take_block();
        logic [OUT_W-1:0] eb;
        bit               el;
        int               d;
        bus.f_ack = 1'b0;
        if (exp_q.size() == 0) begin
            check("unexpected_block", OUT_W'(bus.out_ready), OUT_W'(0));
            eb = bus.out;
            el = 1'b0;
        end else begin
            eb = exp_q.pop_front();
            el = exp_last_q.pop_front();
        end
        check("block", bus.out, eb);
        check("out_last", OUT_W'(bus.out_last), OUT_W'(el));
        check("buffer_full", OUT_W'(bus.buffer_full), OUT_W'(1));
        last_block = bus.out;
        d = (hold_delay >= 0) ? hold_delay : int'($urandom_range(0, 3));
        repeat (d) begin
            @(negedge clk);
            check("hold_stable", bus.out, eb);
            check("hold_ready", OUT_W'(bus.out_ready), OUT_W'(1));
        end
        bus.f_ack = 1'b1;
        @(negedge clk);
        bus.f_ack = 1'b0;
        check("ack_cleared", bus.out, OUT_W'(0));
        check("ack_ready", OUT_W'(bus.out_ready), OUT_W'(0));
    endtask

    // Send one message of n words (all bytes valid except bn in the last word) in mode md.
    task automatic send_msg(input int n, input int bn, input int md);
        logic [63:0]  words[$];
        byte unsigned bq[$];
        int           nblk;
        int           guard;
        logic [OUT_W-1:0] blk;
        for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
        for (int i = 0; i < n; i++) begin
            int nb = (i == n - 1) ? bn : 8;
            for (int k = 0; k < nb; k++) bq.push_back(words[i][63 - 8*k -: 8]);
        end
        bq.push_back(dom_byte(md));
        while (bq.size() % RB != 0) bq.push_back(8'h00);
        bq[bq.size() - 1] = bq[bq.size() - 1] | 8'h80;
        nblk = bq.size() / RB;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int j = 0; j < RB; j++) blk = (blk << 8) | OUT_W'(bq[b*RB + j]);
            exp_q.push_back(blk);
            exp_last_q.push_back(b == nblk - 1);
        end

        for (int i = 0; i < n; i++) begin
            bus.in       = words[i];
            bus.in_ready = 1'b1;
            bus.is_last  = (i == n - 1);
            bus.byte_num = (i == n - 1) ? 3'(bn) : 3'($urandom);
            bus.mode     = (i == 0) ? 2'(md) : 2'($urandom);
            guard = 0;
            while (bus.out_ready && guard < 20) begin
                take_block();
                guard++;
            end
            if (guard >= 20) check("word_wait_timeout", OUT_W'(bus.out_ready), OUT_W'(0));
            bus.f_ack = 1'($urandom);
            @(negedge clk);
            bus.f_ack = 1'b0;
        end
        bus.in_ready = 1'b0;
        bus.is_last  = 1'($urandom);
        bus.byte_num = 3'($urandom);
        bus.mode     = 2'($urandom);
        guard = 0;
        while (exp_q.size() > 0 && guard < 300) begin
            if (bus.out_ready) begin
                take_block();
            end else begin
                bus.f_ack = 1'($urandom);
                @(negedge clk);
                bus.f_ack = 1'b0;
            end
            guard++;
        end
        if (exp_q.size() > 0) begin
            check("block_timeout", OUT_W'(exp_q.size()), OUT_W'(0));
            exp_q.delete();
            exp_last_q.delete();
        end
        repeat (3) begin
            @(negedge clk);
            check("no_extra_block", OUT_W'(bus.out_ready), OUT_W'(0));
        end
    endtask

    initial begin
        bus.in = '0; bus.in_ready = 1'b0; bus.is_last = 1'b0;
        bus.byte_num = '0; bus.mode = '0; bus.f_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_out", bus.out, OUT_W'(0));
        check("rst_out_ready", OUT_W'(bus.out_ready), OUT_W'(0));
        check("rst_buffer_full", OUT_W'(bus.buffer_full), OUT_W'(0));
        check("rst_out_last", OUT_W'(bus.out_last), OUT_W'(0));

        // Empty SHA-3 message: a single pad block.
        send_msg(1, 0, 1);
        check("sha3_empty_word0", OUT_W'(last_block[OUT_W-1 -: 64]), OUT_W'(64'h0600_0000_0000_0000));
        check("sha3_empty_tail", OUT_W'(last_block[63:0]), OUT_W'(64'h80));

        // One full block, then a 3-byte tail word; long hold with a word pending.
        hold_delay = 5;
        send_msg(RW + 1, 3, 0);
        hold_delay = -1;

        // The is_last word lands in the final slot: 0x06 and 0x80 share the last byte.
        send_msg(RW, 7, 1);
        check("sha3_final_byte", OUT_W'(last_block[7:0]), OUT_W'(8'h86));

        send_msg(3, 5, 2);
        send_msg(RW - 1, 7, 2);
        send_msg(2 * RW, 0, 3);

        // Reset in the middle of PAD with in_ready and f_ack also high.
        bus.in = {$urandom, $urandom}; bus.in_ready = 1'b1; bus.is_last = 1'b1;
        bus.byte_num = 3'd2; bus.mode = 2'd1;
        @(negedge clk);
        bus.in_ready = 1'b0; bus.is_last = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; bus.in_ready = 1'b1; bus.f_ack = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.in_ready = 1'b0; bus.f_ack = 1'b0;
        check("midpad_rst_out", bus.out, OUT_W'(0));
        check("midpad_rst_ready", OUT_W'(bus.out_ready), OUT_W'(0));
        check("midpad_rst_full", OUT_W'(bus.buffer_full), OUT_W'(0));
        check("midpad_rst_last", OUT_W'(bus.out_last), OUT_W'(0));
        send_msg(2, 4, 2);

        for (int t = 0; t < 25; t++) begin
            send_msg(int'($urandom_range(1, 3 * RW)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
